instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the processor: generates the program counter, fetches instruction words from instruction memory through a req/ack handshake, and buffers them in a small FIFO.
- Presents the head instruction, its PC and its opcode field to the decode stage. The opcode field is what the control unit decodes.
- Accepts branch/jump redirects from execute and flushes everything fetched on the wrong path.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- INSTR_W, 32, instruction word width. Opcode is bits [INSTR_W-1:INSTR_W-6].
- RESET_PC, 0, PC loaded on reset.
- DEPTH, 2, instruction buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1.
- imem_ack  in  1  memory response valid; only meaningful while imem_req=1.
- imem_rdata  in  INSTR_W  instruction word; valid with imem_ack.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_pc  in  ADDR_W  new fetch target.
- halt  in  1  stop issuing new requests.
- instr_valid  out  1  buffer head valid.
- instr_ready  in  1  decode accepts head.
- instr_out  out  INSTR_W  head instruction.
- pc_out  out  ADDR_W  PC of head instruction.
- opcode_out  out  6  instr_out[INSTR_W-1:INSTR_W-6], to control unit.
- busy  out  1  request outstanding or buffer non-empty.

Behaviour:
Reset
- rst=1 at a clock edge sets: fetch_pc=RESET_PC; FSM=IDLE; buffer empty; discard flag=0.
- All outputs are 0 during and after reset, except imem_addr=RESET_PC.
- rst overrides a pending request or ack; the response is never pushed.

FSM
- IDLE -> REQ: next cycle, when halt=0 and (count + outstanding) < DEPTH.
- REQ: imem_req=1, imem_addr=fetch_pc.
- REQ -> IDLE on imem_ack.
  - Discard flag clear: push {fetch_pc, imem_rdata}; fetch_pc += 4.
  - Discard flag set: drop the data; clear the flag.
- Single-ack latency: 1 cycle minimum. IDLE→REQ costs 1 cycle, so sustained throughput is one instruction per 2 cycles.
- Only one request outstanding. A request is never issued unless a buffer slot is reserved for it, so a push never meets a full buffer.

Redirect (highest priority after reset)
- Effect: fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; buffer flushed; instr_valid=0 next cycle.
- If in REQ without ack: the request stays asserted with the old address until ack, then is discarded (discard flag=1).
- Redirect and imem_ack in the same cycle: data dropped, nothing pushed, fetch_pc=redirect target.
- Redirect and instr_ready in the same cycle: the flush wins; the pop is a don't-care.
- Back-to-back redirects: the last one wins.

Buffer
- FIFO with head on the outputs; pop when instr_valid & instr_ready.
- Push and pop in the same cycle are both honoured and count is unchanged.
- Pointers wrap modulo DEPTH.

PC arithmetic
- Unsigned, modulo 2^ADDR_W: 0xFFFFFFFC + 4 = 0x00000000.

Halt
- Blocks IDLE->REQ only. An outstanding request still completes and is pushed; the buffer still drains.

Busy
- busy = (FSM==REQ) | (count != 0).

Test Plan:
- Reset then free run, memory acks 1 cycle after req, instr_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - pc_out/instr_out match the fetched words in order.
  - opcode_out = instr[31:26]; e.g. word 0x34000000 -> opcode 13.
- Backpressure, instr_ready=0:
  - Exactly DEPTH=2 words accepted, then imem_req stays 0.
  - Raising instr_ready restarts fetch at 0x8 with no loss or duplication.
- Redirect to 0x100 while a request for 0x8 is pending, ack 3 cycles later:
  - 0x8's data is dropped.
  - Next request is at 0x100; first pc_out after the flush is 0x100.
- Redirect coincident with imem_ack, and redirect_pc=0x203:
  - Nothing pushed.
  - Next imem_addr=0x200.
- RESET_PC=0xFFFFFFFC:
  - Second fetch address is 0x00000000.
- Halt asserted while in REQ:
  - Pending word is delivered; no further req.
  - busy falls after the last pop.
  - rst mid-request clears all state, and a stale ack is ignored.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Processor front end. Generates the program counter, fetches instruction
// words from instruction memory over a req/ack handshake (one request in
// flight at a time), and holds them in a small FIFO whose head is presented
// to decode together with its PC and opcode field. Taken branches/jumps from
// execute redirect the fetch PC and flush everything fetched on the wrong
// path.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   imem_req        fetch request, held until imem_ack
//   imem_addr       fetch address (stable while imem_req=1)
//   imem_ack        memory response valid (only looked at while requesting)
//   imem_rdata      instruction word, valid with imem_ack
//   redirect_valid  taken branch/jump from execute
//   redirect_pc     new fetch target (low two bits ignored)
//   halt            stop issuing new requests
//   instr_valid     buffer head valid
//   instr_ready     decode accepts the head this cycle
//   instr_out       head instruction word (0 when empty)
//   pc_out          PC of head instruction (0 when empty)
//   opcode_out      instr_out[INSTR_W-1:INSTR_W-6], for the control unit
//   busy            request outstanding or buffer non-empty
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [5:0]         opcode_out,
  output logic               busy
);

  localparam int unsigned       PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic               discard_q, discard_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;

  logic [INSTR_W-1:0] buf_instr_q [DEPTH];
  logic [ADDR_W-1:0]  buf_pc_q    [DEPTH];

  logic               push;
  logic               pop;
  logic               start;
  logic [ADDR_W-1:0]  redirect_target;
  logic               redirect_lsb_unused;

  // Fetch addresses are word aligned; the byte offset of the target is dropped.
  assign redirect_target     = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic: fetch FSM, PC, discard flag and FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    push       = 1'b0;
    start      = 1'b0;
    // A flush discards the head, so a pop in the redirect cycle is ignored.
    pop        = (count_q != '0) && instr_ready && !redirect_valid;

    case (state_q)
      S_IDLE: begin
        // Only one request in flight, so in IDLE nothing is outstanding and a
        // free slot is guaranteed for the response before we ask for it.
        if (!halt && (count_q < DEPTH_C)) begin
          state_d = S_REQ;
          start   = 1'b1;
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          if (!redirect_valid && !discard_q) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end
        end else if (redirect_valid) begin
          // The bus request cannot be withdrawn; mark its response as stale.
          discard_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
    end

    // Latch the address for the new request so it stays stable on the bus
    // even if a redirect moves fetch_pc while the request is pending.
    if (start) begin
      req_addr_d = fetch_pc_d;
    end

    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
    end
  end

  // ---------------------------------------------------------------------------
  // Control state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      discard_q  <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction buffer storage (data only, validity lives in count_q)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= req_addr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = imem_req ? req_addr_q : fetch_pc_q;
  assign instr_valid = (count_q != '0);
  // Storage is not reset, so the head is forced to zero while empty.
  assign instr_out   = instr_valid ? buf_instr_q[rd_ptr_q] : '0;
  assign pc_out      = instr_valid ? buf_pc_q[rd_ptr_q] : '0;
  assign opcode_out  = instr_out[INSTR_W-1 -: 6];
  assign busy        = imem_req | instr_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [5:0]  op;
  } ent_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [5:0]  opcode_out;
  logic        busy;

  // second instance, wrap-around reset PC
  logic        req2;
  logic [31:0] addr2;
  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        redir2 = 1'b0;
  logic [31:0] rpc2 = '0;
  logic        halt2 = 1'b0;
  logic        valid2;
  logic        ready2 = 1'b1;
  logic [31:0] ins2;
  logic [31:0] pc2;
  logic [5:0]  op2;
  logic        busy2;

  instr_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .pc_out(pc_out),
    .opcode_out(opcode_out), .busy(busy));

  instr_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .redirect_valid(redir2),
    .redirect_pc(rpc2), .halt(halt2), .instr_valid(valid2),
    .instr_ready(ready2), .instr_out(ins2), .pc_out(pc2),
    .opcode_out(op2), .busy(busy2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h3400_0000;
    return (a * 32'h9E37_79B1) ^ 32'hC300_0000;
  endfunction

  // ---------------- memory responder ----------------
  int  mem_cnt = 0;
  int  cur_lat = 0;
  int  fix_lat = 0;
  bit  rand_lat = 1'b0;
  bit  mem_force = 1'b0;

  always @(posedge clk) begin
    #2;
    if (mem_force) begin
      imem_ack   = 1'b1;
      imem_rdata = word_at(imem_addr);
    end else if (imem_req) begin
      if (mem_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
      if (mem_cnt >= cur_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = word_at(imem_addr);
        mem_cnt    = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        mem_cnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      mem_cnt    = 0;
    end
  end

  always @(posedge clk) begin
    #2;
    ack2   = req2;
    rdata2 = word_at(addr2);
  end

  // ---------------- observation logs ----------------
  logic [31:0] req_log[$];
  logic [31:0] q2[$];
  ent_t        pop_log[$];
  int          ack_count = 0;
  bit          req_prev = 1'b0;
  bit          req2_prev = 1'b0;
  logic        s_req = 1'b0, s_valid = 1'b0;
  logic [31:0] s_pc = '0, s_ins = '0;
  logic [5:0]  s_op = '0;

  always @(posedge clk) begin
    #1;
    if (imem_req && !req_prev) req_log.push_back(imem_addr);
    req_prev = imem_req;
    if (req2 && !req2_prev && q2.size() < 4) q2.push_back(addr2);
    req2_prev = req2;
  end

  always @(negedge clk) begin
    s_req   = imem_req;
    s_valid = instr_valid;
    s_pc    = pc_out;
    s_ins   = instr_out;
    s_op    = opcode_out;
  end

  always @(posedge clk) begin
    if (!rst && s_valid && instr_ready && !redirect_valid)
      pop_log.push_back(ent_t'{s_pc, s_ins, s_op});
    if (!rst && s_req && imem_ack) ack_count++;
  end

  function automatic logic [31:0] rq(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic ent_t pq(input int i);
    if (i < pop_log.size()) return pop_log[i];
    return ent_t'{32'hDEAD_BEEF, 32'hDEAD_BEEF, 6'h3F};
  endfunction

  // ---------------- behavioural reference model ----------------
  // The model tracks: the list of fetched-but-unconsumed words, the next PC
  // to fetch, whether a request is on the bus (and its address), and whether
  // that request's answer belongs to a squashed path.
  ent_t        mq[$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_addr = 32'h0;
  bit          m_req = 1'b0;
  bit          m_disc = 1'b0;

  always @(posedge clk) begin
    int          sz;
    bit          m_pop;
    bit          m_start;
    logic [31:0] e_ins;
    if (rst) begin
      m_pc   = 32'h0;
      m_addr = 32'h0;
      m_req  = 1'b0;
      m_disc = 1'b0;
      mq.delete();
    end else begin
      sz      = mq.size();
      m_pop   = (sz > 0) && instr_ready;
      m_start = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (m_req) begin
        if (imem_ack) begin
          m_req = 1'b0;
          if (!redirect_valid && !m_disc) begin
            mq.push_back(ent_t'{m_addr, imem_rdata, imem_rdata[31:26]});
            m_pc = m_addr + 32'd4;
          end
          m_disc = 1'b0;
        end else if (redirect_valid) begin
          m_disc = 1'b1;
        end
      end else if (!halt && sz < DEPTH) begin
        m_req   = 1'b1;
        m_start = 1'b1;
      end
      if (redirect_valid) begin
        mq.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end
      if (m_start) m_addr = m_pc;
    end
    #1;
    e_ins = (mq.size() != 0) ? mq[0].ins : 32'h0;
    chk("imem_req",    {31'd0, imem_req},    {31'd0, m_req});
    chk("imem_addr",   imem_addr,            m_req ? m_addr : m_pc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
    chk("instr_out",   instr_out,            e_ins);
    chk("pc_out",      pc_out,               (mq.size() != 0) ? mq[0].pc : 32'h0);
    chk("opcode_out",  {26'd0, opcode_out},  {26'd0, e_ins[31:26]});
    chk("busy",        {31'd0, busy},        {31'd0, m_req || (mq.size() != 0)});
  end

  // ---------------- directed + random stimulus ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int b, p, a0, n;
    bit found;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_addr",  imem_addr,            32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy},        32'd0);
    chk("rst_instr", instr_out,            32'h0);
    chk("rst_addr2", addr2,                32'hFFFF_FFFC);

    // free run, ack in the cycle after req rises
    b = req_log.size(); p = pop_log.size();
    instr_ready = 1'b1;
    rst = 1'b0;
    repeat (14) @(negedge clk);
    chk("run_addr0", rq(b),     32'h0);
    chk("run_addr1", rq(b + 1), 32'h4);
    chk("run_addr2", rq(b + 2), 32'h8);
    chk("run_pop0_pc",  pq(p).pc,               32'h0);
    chk("run_pop0_ins", pq(p).ins,              32'h3400_0000);
    chk("run_pop0_op",  {26'd0, pq(p).op},      32'd13);
    chk("run_pop1_pc",  pq(p + 1).pc,           32'h4);
    chk("run_pop1_ins", pq(p + 1).ins,          word_at(32'h4));
    chk("wrap_addr0", (q2.size() > 0) ? q2[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_addr1", (q2.size() > 1) ? q2[1] : 32'hDEAD_BEEF, 32'h0);

    // backpressure
    instr_ready = 1'b0;
    fix_lat = 0;
    do_reset();
    a0 = ack_count;
    repeat (20) @(negedge clk);
    chk("bp_acks",  ack_count - a0,        32'd2);
    chk("bp_req",   {31'd0, imem_req},     32'd0);
    chk("bp_valid", {31'd0, instr_valid},  32'd1);
    chk("bp_pc",    pc_out,                32'h0);
    b = req_log.size(); p = pop_log.size();
    instr_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("bp_restart", rq(b), 32'h8);
    chk("bp_pop0", pq(p).pc,     32'h0);
    chk("bp_pop1", pq(p + 1).pc, 32'h4);
    chk("bp_pop2", pq(p + 2).pc, 32'h8);

    // redirect while the request for 0x8 is pending, slow memory
    fix_lat = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = imem_req && (imem_addr == 32'h8);
    end
    chk("redir_wait", {31'd0, found}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    b = req_log.size(); p = pop_log.size();
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (25) @(negedge clk);
    chk("redir_next_req", rq(b),    32'h100);
    chk("redir_first_pc", pq(p).pc, 32'h100);

    // redirect coincident with ack, unaligned target
    fix_lat = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = imem_req && imem_ack;
    end
    chk("coin_wait", {31'd0, found}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    b = req_log.size(); p = pop_log.size();
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("coin_nopush", {31'd0, instr_valid}, 32'd0);
    repeat (10) @(negedge clk);
    chk("coin_next_req", rq(b),    32'h200);
    chk("coin_first_pc", pq(p).pc, 32'h200);

    // halt while a request is outstanding
    fix_lat = 2;
    instr_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = imem_req;
    end
    chk("halt_wait", {31'd0, found}, 32'd1);
    halt = 1'b1;
    a0 = ack_count;
    repeat (10) @(negedge clk);
    chk("halt_acks",  ack_count - a0,        32'd1);
    chk("halt_req",   {31'd0, imem_req},     32'd0);
    chk("halt_valid", {31'd0, instr_valid},  32'd1);
    chk("halt_busy",  {31'd0, busy},         32'd1);
    b = req_log.size();
    instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = !busy;
    end
    chk("halt_drain", {31'd0, found}, 32'd1);
    repeat (5) @(negedge clk);
    n = req_log.size() - b;
    chk("halt_noreq", n, 32'd0);
    halt = 1'b0;

    // reset in the middle of a request, with a stale ack afterwards
    fix_lat = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = imem_req && imem_ack;
    end
    chk("rstmid_wait", {31'd0, found}, 32'd1);
    rst = 1'b1;
    mem_force = 1'b1;
    @(negedge clk);
    chk("rstmid_req",   {31'd0, imem_req},    32'd0);
    chk("rstmid_valid", {31'd0, instr_valid}, 32'd0);
    chk("rstmid_busy",  {31'd0, busy},        32'd0);
    chk("rstmid_addr",  imem_addr,            32'h0);
    b = req_log.size(); p = pop_log.size();
    rst = 1'b0;
    mem_force = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstmid_next_req", rq(b),    32'h0);
    chk("rstmid_first_pc", pq(p).pc, 32'h0);

    // randomized traffic against the model
    rand_lat = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      instr_ready    = ($urandom_range(0, 3) != 0);
      halt           = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom & 32'h0000_0FFF;
    end
    @(negedge clk);
    halt = 1'b0;
    redirect_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
